i2s_source_scheduler: RTL and testbench
=======================================

// Module: i2s_source_scheduler
// PURPOSE
// Frame-paced sample scheduler in front of the I2S transmitter's mono_sample input. Shares
// the single output between a streaming source and a priority chime source. Applies a
// per-frame linear gain ramp so mute, unmute and source switches are click-free.
// Tracks underruns. Runs in the clk domain; frame_tick arrives pre-synchronised from the
// I2S bit-clock domain.
// PARAMETERS
// WIDTH          24  sample width, signed two's complement
// RAMP_LOG2      4   gain steps = 2**RAMP_LOG2 (16), one step per frame
// UNDERRUN_LIMIT 8   consecutive starved frames that force a ramp-down
// PORTS
// clk          in   1      system clock (27 MHz)
// rst_n        in   1      reset: one clock; asynchronous, active-low
// frame_tick   in   1      1-cycle pulse, one per I2S frame
// mute_req     in   1      level; 1 = ramp to silence and stay muted
// strm_data    in   WIDTH  stream sample
// strm_valid   in   1      stream sample available
// strm_ready   out  1      stream consume strobe
// chime_data   in   WIDTH  chime sample
// chime_valid  in   1      chime sample available; chime has priority
// chime_ready  out  1      chime consume strobe
// sample_out   out  WIDTH  gained sample to transmitter, held between ticks
// active_src   out  2      0 none, 1 stream, 2 chime
// underrun     out  1      1-cycle pulse on a starved tick
// underrun_cnt out  8      saturating count of starved ticks
// BEHAVIOUR
// - Reset (async, any time): state MUTED, g=0, cur_src=STREAM, sample_out=0, held=0,
//   active_src=0, underrun=0, underrun_cnt=0, starve=0. Both ready outputs are forced 0
//   while rst_n=0.
// - All state changes happen only on clk edges where frame_tick=1. Back-to-back ticks are
//   each processed.
// - Ready outputs are combinational: src_ready = frame_tick & (src is the consumed source).
//   A transfer occurs when valid & ready are both 1 in the same cycle.
// - The consumed source is cur_src in RAMP_UP, PLAY and RAMP_DOWN. In MUTED the stream is
//   consumed and its data discarded, to keep the stream real-time. The chime is not
//   consumed in MUTED.
// - Datapath, 1-cycle latency: on a tick, held <= transferred data, or held is kept if the
//   source is starved. sample_out <= (held_next * g_next) >>> RAMP_LOG2, computed as a
//   signed product of WIDTH+RAMP_LOG2+1 bits using an arithmetic shift (floor). g = 2**RAMP_LOG2
//   passes the sample unchanged.
// - desired source = CHIME if chime_valid, else STREAM.
// - FSM, evaluated per tick; g_next is the new gain:
//   MUTED: g=0, sample_out <= 0. If !mute_req and desired source is valid:
//     cur_src <= desired, starve <= 0, -> RAMP_UP.
//   RAMP_UP: g+1. At g_next == 2**RAMP_LOG2 -> PLAY.
//     Go to RAMP_DOWN first if mute_req, desired != cur_src, or starve reaches UNDERRUN_LIMIT.
//   PLAY: g held at max. Same exit conditions to RAMP_DOWN as RAMP_UP.
//   RAMP_DOWN: g-1. At g_next == 0 -> MUTED; re-selection then happens on the next tick.
//     A ramp-down is never reversed mid-way, even if its cause clears.
// - Underrun: tick in RAMP_UP/PLAY/RAMP_DOWN while cur_src is not valid. Effects: the held
//   sample is reused, underrun pulses, underrun_cnt += 1 saturating at 255, starve += 1
//   saturating. Any successful transfer clears starve.
// - active_src = 0 when state is MUTED, otherwise cur_src encoding. It updates with the state.
// - A chime that ends during PLAY makes desired = STREAM, which triggers a ramp-down and then
//   a switch back to the stream.
// TESTING
// 1 Reset, stream valid, mute_req=0, strm_data=0x100000: tick1 selects the source (MUTED,
//   out 0). Ticks 2..17 give out = 0x10000*k for k=1..16. Tick 17 reaches PLAY with out=0x100000.
// 2 In PLAY, chime_valid=1 with data 0x200000: 16 ticks ramp down on the stream with
//   chime_ready=0, then MUTED, then the chime ramps up. active_src goes 1 -> 0 -> 2.
// 3 Stream held at -1 (0xFFFFFF), g=1: out=0xFFFFFF (floor). g=16: out=0xFFFFFF.
// 4 In PLAY, strm_valid=0 for 10 ticks: out holds the last value, underrun pulses every tick,
//   underrun_cnt=10. The 8th starved tick starts RAMP_DOWN.
// 5 mute_req=1 at g=5 during RAMP_UP: g goes 4,3,2,1,0, then MUTED. strm_ready still pulses
//   on ticks and out stays 0.
// 6 Assert rst_n=0 mid-PLAY between ticks: sample_out=0 and active_src=0 immediately.
//   300 starved ticks saturate underrun_cnt at 255.

Source files
------------

// File: rtl/i2s_source_scheduler.sv
// Frame-paced sample scheduler feeding the I2S transmitter.
// Arbitrates stream/chime sources with a click-free gain ramp.
`timescale 1ns/1ps
module i2s_source_scheduler #(
  parameter int WIDTH          = 24,
  parameter int RAMP_LOG2      = 4,
  parameter int UNDERRUN_LIMIT = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             frame_tick,
  input  logic             mute_req,
  input  logic [WIDTH-1:0] strm_data,
  input  logic             strm_valid,
  output logic             strm_ready,
  input  logic [WIDTH-1:0] chime_data,
  input  logic             chime_valid,
  output logic             chime_ready,
  output logic [WIDTH-1:0] sample_out,
  output logic [1:0]       active_src,
  output logic             underrun,
  output logic [7:0]       underrun_cnt
);

  localparam int GW = RAMP_LOG2 + 1;
  localparam int PW = WIDTH + RAMP_LOG2 + 1;
  localparam logic [GW-1:0] G_MAX = GW'(1 << RAMP_LOG2);

  localparam logic [1:0] S_MUTED = 2'd0;
  localparam logic [1:0] S_UP    = 2'd1;
  localparam logic [1:0] S_PLAY  = 2'd2;
  localparam logic [1:0] S_DOWN  = 2'd3;

  localparam logic SRC_STRM  = 1'b0;
  localparam logic SRC_CHIME = 1'b1;

  logic [1:0]       state, state_n;
  logic [GW-1:0]    g, g_n;
  logic             cur_src, src_n;
  logic [WIDTH-1:0] held, held_n;
  logic [7:0]       starve, starve_n;

  logic             is_muted;
  logic             cur_valid;
  logic [WIDTH-1:0] cur_data;
  logic             desired;
  logic             starved;
  logic             leave;
  logic signed [PW-1:0] held_x;
  logic signed [PW-1:0] g_x;
  logic signed [PW-1:0] prod;
  logic [WIDTH-1:0] out_n;

  assign is_muted  = (state == S_MUTED);
  assign cur_valid = cur_src ? chime_valid : strm_valid;
  assign cur_data  = cur_src ? chime_data : strm_data;
  assign desired   = chime_valid ? SRC_CHIME : SRC_STRM;
  assign starved   = !is_muted && !cur_valid;

  // Muted keeps draining the stream so it stays real-time
  assign strm_ready  = rst_n & frame_tick
                     & (is_muted | (cur_src == SRC_STRM));
  assign chime_ready = rst_n & frame_tick
                     & !is_muted & (cur_src == SRC_CHIME);

  // Next-state, gain and held-sample selection for one frame
  always_comb begin
    state_n  = state;
    g_n      = g;
    src_n    = cur_src;
    held_n   = held;
    starve_n = starve;
    if (!is_muted) begin
      if (cur_valid) begin
        held_n   = cur_data;
        starve_n = '0;
      end else if (starve != 8'hFF) begin
        starve_n = starve + 8'd1;
      end
    end
    leave = mute_req || (desired != cur_src)
         || (starve_n >= 8'(UNDERRUN_LIMIT));
    unique case (state)
      S_MUTED: begin
        g_n = '0;
        if (!mute_req && (chime_valid || strm_valid)) begin
          src_n    = desired;
          starve_n = '0;
          state_n  = S_UP;
        end
      end
      S_UP: begin
        if (leave) begin
          g_n     = (g == '0) ? '0 : g - GW'(1);
          state_n = (g <= GW'(1)) ? S_MUTED : S_DOWN;
        end else begin
          g_n = g + GW'(1);
          if (g + GW'(1) == G_MAX) state_n = S_PLAY;
        end
      end
      S_PLAY: begin
        if (leave) begin
          g_n     = g - GW'(1);
          state_n = S_DOWN;
        end
      end
      S_DOWN: begin
        g_n = g - GW'(1);
        if (g == GW'(1)) state_n = S_MUTED;
      end
      default: begin
        g_n     = '0;
        state_n = S_MUTED;
      end
    endcase
  end

  // Signed gain multiply, floor via arithmetic shift
  always_comb begin
    held_x = {{(PW-WIDTH){held_n[WIDTH-1]}}, held_n};
    g_x    = {{(PW-GW){1'b0}}, g_n};
    prod   = held_x * g_x;
    out_n  = WIDTH'(prod >>> RAMP_LOG2);
  end

  // Frame-tick state update and underrun bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_MUTED;
      g            <= '0;
      cur_src      <= SRC_STRM;
      held         <= '0;
      starve       <= '0;
      sample_out   <= '0;
      active_src   <= 2'd0;
      underrun     <= 1'b0;
      underrun_cnt <= 8'd0;
    end else begin
      underrun <= frame_tick && starved;
      if (frame_tick) begin
        state      <= state_n;
        g          <= g_n;
        cur_src    <= src_n;
        held       <= held_n;
        starve     <= starve_n;
        sample_out <= out_n;
        if (state_n == S_MUTED)
          active_src <= 2'd0;
        else
          active_src <= src_n ? 2'd2 : 2'd1;
        if (starved && underrun_cnt != 8'hFF)
          underrun_cnt <= underrun_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_i2s_source_scheduler.sv
// Bench for i2s_source_scheduler.
// Reference model works in integers per frame.
`timescale 1ns/1ps
module tb_i2s_source_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_tick = 1'b0;
  logic        mute_req = 1'b0;
  logic [23:0] strm_data = '0;
  logic        strm_valid = 1'b0;
  logic        strm_ready;
  logic [23:0] chime_data = '0;
  logic        chime_valid = 1'b0;
  logic        chime_ready;
  logic [23:0] sample_out;
  logic [1:0]  active_src;
  logic        underrun;
  logic [7:0]  underrun_cnt;

  i2s_source_scheduler dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .frame_tick   (frame_tick),
    .mute_req     (mute_req),
    .strm_data    (strm_data),
    .strm_valid   (strm_valid),
    .strm_ready   (strm_ready),
    .chime_data   (chime_data),
    .chime_valid  (chime_valid),
    .chime_ready  (chime_ready),
    .sample_out   (sample_out),
    .active_src   (active_src),
    .underrun     (underrun),
    .underrun_cnt (underrun_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // model: mode 0 muted, 1 ramp up, 2 play, 3 ramp down
  // src 1 stream, 2 chime
  int m_mode, m_g, m_src, m_held, m_starve;
  int m_cnt, m_out, m_act;
  bit m_und;
  bit exp_sr, exp_cr, obs_sr, obs_cr;

  task automatic m_reset();
    m_mode = 0; m_g = 0; m_src = 1; m_held = 0;
    m_starve = 0; m_cnt = 0; m_out = 0; m_act = 0;
    m_und = 0;
  endtask

  task automatic m_step();
    int want, p;
    bit have, leave;
    want = chime_valid ? 2 : 1;
    if (m_mode == 0) begin
      m_und = 0;
      m_g = 0;
      if (!mute_req && (chime_valid || strm_valid)) begin
        m_src = want;
        m_starve = 0;
        m_mode = 1;
      end
    end else begin
      have = (m_src == 2) ? chime_valid : strm_valid;
      if (have) begin
        m_held = (m_src == 2) ? $signed(chime_data)
                              : $signed(strm_data);
        m_starve = 0;
        m_und = 0;
      end else begin
        m_und = 1;
        if (m_cnt < 255) m_cnt++;
        if (m_starve < 255) m_starve++;
      end
      leave = mute_req || (want != m_src) || (m_starve >= 8);
      if (m_mode == 1) begin
        if (leave) begin
          if (m_g > 0) m_g--;
          m_mode = (m_g == 0) ? 0 : 3;
        end else begin
          m_g++;
          if (m_g == 16) m_mode = 2;
        end
      end else if (m_mode == 2) begin
        if (leave) begin
          m_g--;
          m_mode = 3;
        end
      end else begin
        m_g--;
        if (m_g == 0) m_mode = 0;
      end
    end
    p = m_held * m_g;
    m_out = (p >= 0) ? p / 16 : -((-p + 15) / 16);
    m_act = (m_mode == 0) ? 0 : m_src;
  endtask

  task automatic do_reset();
    frame_tick = 0;
    @(negedge clk);
    rst_n = 0;
    #2;
    @(negedge clk);
    rst_n = 1;
    m_reset();
  endtask

  // one frame tick; idle=0 keeps frame_tick high back-to-back
  task automatic do_tick(input int idle);
    if (idle > 0) begin
      frame_tick = 0;
      repeat (idle) @(posedge clk);
      #1;
      m_und = 0;
    end
    @(negedge clk);
    frame_tick = 1;
    #1;
    obs_sr = strm_ready;
    obs_cr = chime_ready;
    exp_sr = (m_mode == 0) || (m_src == 1);
    exp_cr = (m_mode != 0) && (m_src == 2);
    m_step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    frame_tick = 0;
    rst_n = 0;
    strm_valid = 1;
    chime_valid = 1;
    #3;
    frame_tick = 1;
    #1;
    n_chk++;
    if ({strm_ready, chime_ready} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_ready got %b%b want 00",
               strm_ready, chime_ready);
    end
    n_chk++;
    if ({sample_out, active_src, underrun, underrun_cnt}
        !== 35'd0) begin
      n_fail++;
      $display("FAIL reset_out out=%h src=%0d ur=%b cnt=%0d want 0",
               sample_out, active_src, underrun, underrun_cnt);
    end
    frame_tick = 0;
    strm_valid = 0;
    chime_valid = 0;
    @(negedge clk);
    rst_n = 1;
    m_reset();
  endtask

  task automatic test_ramp_up();
    strm_valid = 1;
    strm_data = 24'h100000;
    chime_valid = 0;
    mute_req = 0;
    for (int k = 0; k < 17; k++) begin
      do_tick(k % 2);
      n_chk++;
      if (sample_out !== m_out[23:0] || active_src !== m_act[1:0]
          || obs_sr !== exp_sr || obs_cr !== exp_cr) begin
        n_fail++;
        $display("FAIL ramp_up t%0d out=%h src=%0d rdy=%b%b want %h %0d %b%b",
                 k, sample_out, active_src, obs_sr, obs_cr,
                 m_out[23:0], m_act, exp_sr, exp_cr);
      end
    end
    n_chk++;
    if (sample_out !== 24'h100000) begin
      n_fail++;
      $display("FAIL ramp_up_full out=%h want 100000", sample_out);
    end
  endtask

  task automatic test_switch();
    chime_valid = 1;
    chime_data = 24'h200000;
    for (int k = 0; k < 34; k++) begin
      do_tick(0);
      n_chk++;
      if (sample_out !== m_out[23:0] || active_src !== m_act[1:0]
          || obs_sr !== exp_sr || obs_cr !== exp_cr) begin
        n_fail++;
        $display("FAIL switch t%0d out=%h src=%0d rdy=%b%b want %h %0d %b%b",
                 k, sample_out, active_src, obs_sr, obs_cr,
                 m_out[23:0], m_act, exp_sr, exp_cr);
      end
      if (k == 15) begin
        n_chk++;
        if (active_src !== 2'd0) begin
          n_fail++;
          $display("FAIL switch_muted src=%0d want 0", active_src);
        end
      end
    end
    n_chk++;
    if (active_src !== 2'd2 || sample_out !== 24'h200000) begin
      n_fail++;
      $display("FAIL switch_chime src=%0d out=%h want 2 200000",
               active_src, sample_out);
    end
    chime_valid = 0;
    for (int k = 0; k < 36; k++) begin
      do_tick(1);
      n_chk++;
      if (sample_out !== m_out[23:0] || active_src !== m_act[1:0]
          || obs_sr !== exp_sr || obs_cr !== exp_cr) begin
        n_fail++;
        $display("FAIL switch_back t%0d out=%h src=%0d want %h %0d",
                 k, sample_out, active_src, m_out[23:0], m_act);
      end
    end
    n_chk++;
    if (active_src !== 2'd1) begin
      n_fail++;
      $display("FAIL switch_back_src src=%0d want 1", active_src);
    end
  endtask

  task automatic test_floor();
    do_reset();
    strm_valid = 1;
    strm_data = 24'hFFFFFF;
    do_tick(0);
    do_tick(0);
    n_chk++;
    if (sample_out !== 24'hFFFFFF) begin
      n_fail++;
      $display("FAIL floor_g1 out=%h want ffffff", sample_out);
    end
    for (int k = 0; k < 15; k++) begin
      strm_data = (k == 14) ? 24'hFFFFFF : 24'($urandom);
      do_tick(0);
      n_chk++;
      if (sample_out !== m_out[23:0]) begin
        n_fail++;
        $display("FAIL floor t%0d out=%h want %h",
                 k, sample_out, m_out[23:0]);
      end
    end
    n_chk++;
    if (sample_out !== 24'hFFFFFF) begin
      n_fail++;
      $display("FAIL floor_g16 out=%h want ffffff", sample_out);
    end
  endtask

  task automatic test_underrun();
    do_reset();
    strm_valid = 1;
    strm_data = 24'h0ABCDE;
    repeat (17) do_tick(0);
    strm_valid = 0;
    for (int k = 0; k < 10; k++) begin
      do_tick(k % 2);
      n_chk++;
      if (sample_out !== m_out[23:0] || underrun !== m_und
          || underrun_cnt !== m_cnt[7:0]
          || active_src !== m_act[1:0]) begin
        n_fail++;
        $display("FAIL underrun t%0d out=%h ur=%b cnt=%0d want %h %b %0d",
                 k, sample_out, underrun, underrun_cnt,
                 m_out[23:0], m_und, m_cnt);
      end
      if (k < 7) begin
        n_chk++;
        if (sample_out !== 24'h0ABCDE) begin
          n_fail++;
          $display("FAIL underrun_hold out=%h want 0abcde", sample_out);
        end
      end
    end
    n_chk++;
    if (underrun_cnt !== 8'd10) begin
      n_fail++;
      $display("FAIL underrun_cnt got %0d want 10", underrun_cnt);
    end
  endtask

  task automatic test_mute();
    do_reset();
    strm_valid = 1;
    strm_data = 24'h3FFFF0;
    repeat (6) do_tick(0);
    mute_req = 1;
    for (int k = 0; k < 9; k++) begin
      do_tick(0);
      n_chk++;
      if (sample_out !== m_out[23:0] || active_src !== m_act[1:0]
          || obs_sr !== exp_sr || obs_cr !== exp_cr) begin
        n_fail++;
        $display("FAIL mute t%0d out=%h src=%0d rdy=%b want %h %0d %b",
                 k, sample_out, active_src, obs_sr,
                 m_out[23:0], m_act, exp_sr);
      end
      if (k == 0) begin
        n_chk++;
        if (sample_out !== 24'(32'h3FFFF0 * 4 / 16)) begin
          n_fail++;
          $display("FAIL mute_g4 out=%h", sample_out);
        end
      end
    end
    n_chk++;
    if (sample_out !== 24'd0 || obs_sr !== 1'b1) begin
      n_fail++;
      $display("FAIL mute_hold out=%h sr=%b want 0 1",
               sample_out, obs_sr);
    end
    mute_req = 0;
  endtask

  task automatic test_random(input bit b2b);
    for (int k = 0; k < 250; k++) begin
      strm_valid = ($urandom_range(0, 7) != 0);
      strm_data = 24'($urandom);
      chime_data = 24'($urandom);
      if ($urandom_range(0, 19) == 0) chime_valid = ~chime_valid;
      if ($urandom_range(0, 29) == 0) mute_req = ~mute_req;
      do_tick(b2b ? 0 : int'($urandom_range(0, 2)));
      n_chk++;
      if (sample_out !== m_out[23:0] || active_src !== m_act[1:0]
          || underrun !== m_und || underrun_cnt !== m_cnt[7:0]
          || obs_sr !== exp_sr || obs_cr !== exp_cr) begin
        n_fail++;
        $display("FAIL random t%0d out=%h src=%0d ur=%b cnt=%0d rdy=%b%b want %h %0d %b %0d %b%b",
                 k, sample_out, active_src, underrun, underrun_cnt,
                 obs_sr, obs_cr, m_out[23:0], m_act, m_und, m_cnt,
                 exp_sr, exp_cr);
      end
    end
    mute_req = 0;
    chime_valid = 0;
  endtask

  task automatic test_back_to_back();
    do_reset();
    test_random(1'b1);
  endtask

  task automatic test_async_reset();
    do_reset();
    strm_valid = 1;
    strm_data = 24'h123456;
    repeat (17) do_tick(0);
    frame_tick = 0;
    @(posedge clk);
    #3;
    rst_n = 0;
    #1;
    n_chk++;
    if (sample_out !== 24'd0 || active_src !== 2'd0) begin
      n_fail++;
      $display("FAIL async_reset out=%h src=%0d want 0 0",
               sample_out, active_src);
    end
    @(negedge clk);
    rst_n = 1;
    m_reset();
    for (int k = 0; k < 420; k++) begin
      strm_valid = (m_mode == 0);
      strm_data = 24'($urandom);
      do_tick(int'($urandom_range(0, 1)));
      n_chk++;
      if (underrun_cnt !== m_cnt[7:0] || underrun !== m_und
          || sample_out !== m_out[23:0]) begin
        n_fail++;
        $display("FAIL saturate t%0d cnt=%0d ur=%b out=%h want %0d %b %h",
                 k, underrun_cnt, underrun, sample_out,
                 m_cnt, m_und, m_out[23:0]);
      end
    end
    n_chk++;
    if (underrun_cnt !== 8'd255) begin
      n_fail++;
      $display("FAIL saturate_cnt got %0d want 255", underrun_cnt);
    end
  endtask

  initial begin
    m_reset();
    test_reset();
    test_ramp_up();
    test_switch();
    test_floor();
    test_underrun();
    test_mute();
    test_back_to_back();
    do_reset();
    test_random(1'b0);
    test_async_reset();
    frame_tick = 0;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
